// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared types and helpers for the 1-D convolution engine.
//   state_e     - engine control states (LOAD, MAC, HOLD)
//   acc_width   - accumulator width that cannot overflow for M products of
//                 two W-bit signed operands
//   cnt_width   - bits needed to hold a count in 0..n (never less than 1)
//   sat_relu    - clamp a wide sum to the W-bit signed range, then
//                 optionally zero negative values
package conv1d_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Working width of sat_relu; the accumulator must fit inside it.
    localparam int ACC_MAX_W = 64;

    function automatic int acc_width(input int w, input int m);
        return 2 * w + $clog2(m);
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic logic signed [ACC_MAX_W-1:0] sat_relu(
        input logic signed [ACC_MAX_W-1:0] a,
        input int                          w,
        input logic                        relu
    );
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        logic signed [ACC_MAX_W-1:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (a > hi) begin
            r = hi;
        end else if (a < lo) begin
            r = lo;
        end else begin
            r = a;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1d_engine_if.sv
// conv1d_engine_if: the three streams of the convolution engine.
//   x stream : s_data_in_x / s_valid_x / s_ready_x  (input samples)
//   f stream : s_data_in_f / s_valid_f / s_ready_f  (filter coefficients)
//   y stream : m_data_out_y / m_valid_y / m_ready_y (results)
// slave  - engine side (consumes x and f, produces y)
// master - environment side (produces x and f, consumes y)
interface conv1d_engine_if #(
    parameter int W = 16
) ();
    logic signed [W-1:0] s_data_in_x;
    logic                s_valid_x;
    logic                s_ready_x;
    logic signed [W-1:0] s_data_in_f;
    logic                s_valid_f;
    logic                s_ready_f;
    logic signed [W-1:0] m_data_out_y;
    logic                m_valid_y;
    logic                m_ready_y;

    modport slave (
        input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
        output s_ready_x, s_ready_f, m_data_out_y, m_valid_y
    );

    modport master (
        output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
        input  s_ready_x, s_ready_f, m_data_out_y, m_valid_y
    );
endinterface

// File: rtl/conv1d_mac.sv
// conv1d_mac: multiply-accumulate datapath with saturation/ReLU output.
//   clk, reset : clock and asynchronous active-low reset
//   clear      : zero the accumulator (has priority over enable)
//   enable     : add x*f into the accumulator this cycle
//   x, f       : signed operands of the current tap
//   acc        : registered accumulator
//   result     : saturated (and optionally ReLU'd) value of acc + x*f,
//                i.e. what the accumulator becomes after this tap
module conv1d_mac
    import conv1d_pkg::*;
#(
    parameter int W    = 16,
    parameter int M    = 4,
    parameter int RELU = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             enable,
    input  logic signed [W-1:0]              x,
    input  logic signed [W-1:0]              f,
    output logic signed [acc_width(W,M)-1:0] acc,
    output logic signed [W-1:0]              result
);
    localparam int AW = acc_width(W, M);

    logic signed [2*W-1:0]       prod_s;
    logic signed [AW-1:0]        sum_s;
    logic signed [AW-1:0]        acc_d;
    logic signed [AW-1:0]        acc_q;
    logic signed [ACC_MAX_W-1:0] sat_s;

    // Product, running sum, next accumulator and the clamped output value.
    always_comb begin
        prod_s = (2*W)'(x) * (2*W)'(f);
        sum_s  = acc_q + AW'(prod_s);
        if (clear) begin
            acc_d = {AW{1'b0}};
        end else if (enable) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
        sat_s  = sat_relu(ACC_MAX_W'(sum_s), W, RELU != 0);
        result = sat_s[W-1:0];
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= {AW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv1d_engine.sv
// conv1d_engine: streaming 1-D convolution y[k] = sum_j x[k+j]*f[j],
// k = 0..N-M, one tap per cycle.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   io    : conv1d_engine_if.slave carrying the x, f and y streams
// A full x vector (N samples) and f vector (M coefficients) are collected
// in LOAD, then each result takes M MAC cycles and is presented in HOLD
// until consumed. After the last result both buffers must be refilled.
module conv1d_engine
    import conv1d_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int W    = 16,
    parameter int RELU = 0
) (
    input  logic            clk,
    input  logic            reset,
    conv1d_engine_if.slave  io
);
    localparam int XCW = cnt_width(N);
    localparam int FCW = cnt_width(M);
    localparam int XIW = cnt_width(N - 1);
    localparam int FIW = cnt_width(M - 1);
    localparam int KW  = cnt_width(N - M);
    localparam int AW  = acc_width(W, M);

    state_e              state_q, state_d;
    logic [XCW-1:0]      x_cnt_q, x_cnt_d;
    logic [FCW-1:0]      f_cnt_q, f_cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [FIW-1:0]      tap_q, tap_d;
    logic                s_ready_x_q, s_ready_x_d;
    logic                s_ready_f_q, s_ready_f_d;
    logic                m_valid_q, m_valid_d;
    logic signed [W-1:0] m_data_q, m_data_d;

    // Sample storage carries no reset: counts alone decide what is valid.
    logic signed [W-1:0] x_buf_q [N];
    logic signed [W-1:0] f_buf_q [M];

    logic                x_acc_s, f_acc_s;
    logic [XIW-1:0]      x_rd_idx_s;
    logic                mac_clear_s, mac_en_s;
    logic signed [W-1:0] mac_result_s;
    logic signed [AW-1:0] mac_acc_unused_s;

    assign x_acc_s     = io.s_valid_x && s_ready_x_q;
    assign f_acc_s     = io.s_valid_f && s_ready_f_q;
    assign x_rd_idx_s  = XIW'(k_q) + XIW'(tap_q);
    assign mac_en_s    = (state_q == MAC);
    // Holding the accumulator at zero outside MAC means every result
    // starts from a clean sum without a separate clear cycle.
    assign mac_clear_s = (state_q != MAC);

    conv1d_mac #(.W(W), .M(M), .RELU(RELU)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear_s),
        .enable (mac_en_s),
        .x      (x_buf_q[x_rd_idx_s]),
        .f      (f_buf_q[tap_q]),
        .acc    (mac_acc_unused_s),
        .result (mac_result_s)
    );

    // Buffer fill in arrival order.
    always_ff @(posedge clk) begin
        if (x_acc_s) begin
            x_buf_q[x_cnt_q[XIW-1:0]] <= io.s_data_in_x;
        end
        if (f_acc_s) begin
            f_buf_q[f_cnt_q[FIW-1:0]] <= io.s_data_in_f;
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        f_cnt_d   = f_cnt_q;
        k_d       = k_q;
        tap_d     = tap_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        case (state_q)
            LOAD: begin
                if (x_acc_s) begin
                    x_cnt_d = x_cnt_q + XCW'(1);
                end else begin
                    x_cnt_d = x_cnt_q;
                end
                if (f_acc_s) begin
                    f_cnt_d = f_cnt_q + FCW'(1);
                end else begin
                    f_cnt_d = f_cnt_q;
                end
                // Registered counts: leave LOAD the cycle after both fill.
                if ((x_cnt_q == XCW'(N)) && (f_cnt_q == FCW'(M))) begin
                    state_d = MAC;
                    k_d     = {KW{1'b0}};
                    tap_d   = {FIW{1'b0}};
                end else begin
                    state_d = LOAD;
                end
            end
            MAC: begin
                if (tap_q == FIW'(M - 1)) begin
                    state_d   = HOLD;
                    tap_d     = {FIW{1'b0}};
                    m_valid_d = 1'b1;
                    m_data_d  = mac_result_s;
                end else begin
                    tap_d     = tap_q + FIW'(1);
                end
            end
            HOLD: begin
                if (io.m_ready_y) begin
                    m_valid_d = 1'b0;
                    m_data_d  = {W{1'b0}};
                    if (k_q == KW'(N - M)) begin
                        state_d = LOAD;
                        x_cnt_d = {XCW{1'b0}};
                        f_cnt_d = {FCW{1'b0}};
                        k_d     = {KW{1'b0}};
                    end else begin
                        state_d = MAC;
                        k_d     = k_q + KW'(1);
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d   = LOAD;
                m_valid_d = 1'b0;
                m_data_d  = {W{1'b0}};
            end
        endcase
        s_ready_x_d = (state_d == LOAD) && (x_cnt_d < XCW'(N));
        s_ready_f_d = (state_d == LOAD) && (f_cnt_d < FCW'(M));
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            x_cnt_q     <= {XCW{1'b0}};
            f_cnt_q     <= {FCW{1'b0}};
            k_q         <= {KW{1'b0}};
            tap_q       <= {FIW{1'b0}};
            s_ready_x_q <= 1'b0;
            s_ready_f_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= {W{1'b0}};
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            f_cnt_q     <= f_cnt_d;
            k_q         <= k_d;
            tap_q       <= tap_d;
            s_ready_x_q <= s_ready_x_d;
            s_ready_f_q <= s_ready_f_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
        end
    end

    assign io.s_ready_x    = s_ready_x_q;
    assign io.s_ready_f    = s_ready_f_q;
    assign io.m_valid_y    = m_valid_q;
    assign io.m_data_out_y = m_data_q;

endmodule

// File: tb/tb_conv1d_engine.sv
// tb_conv1d_engine: drives two engines (RELU=0 and RELU=1) with identical
// streams and compares every cycle against a plain-arithmetic model of
// the convolution, its saturation/ReLU rule and its handshake timing.
module tb_conv1d_engine;
    localparam int N    = 16;
    localparam int M    = 4;
    localparam int W    = 16;
    localparam int NOUT = N - M + 1;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv1d_engine_if #(.W(W)) if0 ();
    conv1d_engine_if #(.W(W)) if1 ();

    conv1d_engine #(.N(N), .M(M), .W(W), .RELU(0)) dut0 (
        .clk(clk), .reset(reset), .io(if0)
    );
    conv1d_engine #(.N(N), .M(M), .W(W), .RELU(1)) dut1 (
        .clk(clk), .reset(reset), .io(if1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int xv [N];
    int fv [M];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: direct sum, clamp to 16-bit signed, optional ReLU.
    function automatic longint ref_y(input int k, input bit relu);
        longint s = 0;
        for (int j = 0; j < M; j++) s += longint'(xv[k+j]) * longint'(fv[j]);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic set_inputs(input bit vx, input int dx, input bit vf, input int df, input bit mr);
        if0.s_valid_x = vx; if0.s_data_in_x = 16'(dx);
        if0.s_valid_f = vf; if0.s_data_in_f = 16'(df);
        if0.m_ready_y = mr;
        if1.s_valid_x = vx; if1.s_data_in_x = 16'(dx);
        if1.s_valid_f = vf; if1.s_data_in_f = 16'(df);
        if1.m_ready_y = mr;
    endtask

    task automatic check_idle_outputs(input string tag, input bit exp_ready);
        check_val({tag, " ready_x0"}, if0.s_ready_x, exp_ready);
        check_val({tag, " ready_f0"}, if0.s_ready_f, exp_ready);
        check_val({tag, " ready_x1"}, if1.s_ready_x, exp_ready);
        check_val({tag, " ready_f1"}, if1.s_ready_f, exp_ready);
        check_val({tag, " valid0"}, if0.m_valid_y, 0);
        check_val({tag, " valid1"}, if1.m_valid_y, 0);
        check_val({tag, " data0"}, if0.m_data_out_y, 0);
        check_val({tag, " data1"}, if1.m_data_out_y, 0);
    endtask

    // Enter at a negedge; leave at a negedge with reset released.
    task automatic apply_reset(input string tag);
        set_inputs(1'b0, 0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        #1;
        check_idle_outputs({tag, " in_reset"}, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs({tag, " after_reset"}, 1'b1);
    endtask

    // One vector through both engines. stall_k/stall_len hold m_ready low
    // on that result; abort_after stops once that many results are taken.
    task automatic run_vector(input string name, input bit rand_mode,
                              input int stall_k, input int stall_len, input int abort_after);
        int  xi = 0, fi = 0, oi = 0, cyc = 0, stall = 0;
        int  exp_rise = NEVER;
        bit  vx, vf, mr, hx, hf, hy, exp_v;
        longint e0, e1;
        while (oi < NOUT && cyc < 2000 && !(abort_after > 0 && oi == abort_after)) begin
            exp_v = (cyc >= exp_rise);
            e0 = exp_v ? ref_y(oi, 1'b0) : 0;
            e1 = exp_v ? ref_y(oi, 1'b1) : 0;
            check_val({name, " ready_x0"}, if0.s_ready_x, xi < N);
            check_val({name, " ready_f0"}, if0.s_ready_f, fi < M);
            check_val({name, " ready_x1"}, if1.s_ready_x, xi < N);
            check_val({name, " ready_f1"}, if1.s_ready_f, fi < M);
            check_val({name, " valid0"}, if0.m_valid_y, exp_v);
            check_val({name, " valid1"}, if1.m_valid_y, exp_v);
            check_val({name, " y0"}, if0.m_data_out_y, e0);
            check_val({name, " y1"}, if1.m_data_out_y, e1);

            vx = (xi < N) && (!rand_mode || $urandom_range(0, 3) != 0);
            vf = (fi < M) && (!rand_mode || $urandom_range(0, 3) != 0);
            if (oi == stall_k && stall < stall_len && exp_v) begin
                mr = 1'b0;
                stall++;
            end else begin
                mr = !rand_mode || ($urandom_range(0, 2) != 0);
            end
            set_inputs(vx, (xi < N) ? xv[xi] : 0, vf, (fi < M) ? fv[fi] : 0, mr);
            hx = vx && if0.s_ready_x;
            hf = vf && if0.s_ready_f;
            hy = mr && if0.m_valid_y;

            @(posedge clk);
            cyc++;
            if (hx) xi++;
            if (hf) fi++;
            if ((hx || hf) && xi == N && fi == M) exp_rise = cyc + M + 1;
            if (hy) begin
                oi++;
                exp_rise = (oi < NOUT) ? cyc + M : NEVER;
            end
            @(negedge clk);
        end
        set_inputs(1'b0, 0, 1'b0, 0, 1'b0);
        if (!(abort_after > 0 && oi == abort_after)) begin
            check_val({name, " results"}, oi, NOUT);
            if (oi == NOUT) check_idle_outputs({name, " rearm"}, 1'b1);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) xv[i] = i + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        @(negedge clk);
        apply_reset("por");

        load_ramp();
        for (int j = 0; j < M; j++) fv[j] = 1;
        run_vector("basic", 1'b0, -1, 0, 0);

        for (int i = 0; i < N; i++) xv[i] = 32767;
        for (int j = 0; j < M; j++) fv[j] = 32767;
        run_vector("sat_hi", 1'b0, -1, 0, 0);

        for (int i = 0; i < N; i++) xv[i] = -32768;
        run_vector("sat_lo", 1'b0, -1, 0, 0);

        load_ramp();
        fv[0] = -1; fv[1] = 0; fv[2] = 0; fv[3] = 0;
        run_vector("relu", 1'b0, -1, 0, 0);

        for (int j = 0; j < M; j++) fv[j] = 1;
        run_vector("backpressure", 1'b0, 3, 5, 0);

        run_vector("abort", 1'b0, -1, 0, 5);
        apply_reset("midrun");
        run_vector("after_reset", 1'b0, -1, 0, 0);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N; i++)
                xv[i] = (v % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                     : int'($urandom_range(0, 600)) - 300;
            for (int j = 0; j < M; j++)
                fv[j] = (v % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                     : int'($urandom_range(0, 600)) - 300;
            run_vector("random", 1'b1, int'($urandom_range(0, NOUT - 1)),
                       int'($urandom_range(0, 6)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
